csr_unit: RTL and testbench

- Execute-stage sequencer for Zicsr instructions (CSRRW/S/C and the immediate forms CSRRWI/SI/CI).
- Accepts one decoded CSR instruction per transaction over a valid/ready handshake.
- Performs read-modify-write against the CSR register file: combinational read port, synchronous write port.
- Returns the old CSR value for rd. Pulses a pipeline flush after any CSR write, because mstatus/satp/mtvec changes affect younger instructions.

---
 rtl/csr_pkg.sv | 31 +++
 rtl/csr_alu.sv | 42 ++++
 rtl/csr_unit.sv | 154 +++++++++++++++
 tb/tb_csr_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared types and helpers for the Zicsr execute-stage sequencer.
package csr_pkg;

  localparam int unsigned CSR_XLEN   = 64;
  localparam int unsigned CSR_ADDR_W = 12;

  typedef logic [CSR_XLEN-1:0]   word_t;
  typedef logic [CSR_ADDR_W-1:0] csr_addr_t;

  // Top two address bits 2'b11 mark a read-only CSR.
  localparam logic [1:0] CSR_RO_BITS = 2'b11;

  // Encoded on funct3[1:0]; 2'b00 is not a CSR operation.
  typedef enum logic [1:0] {
    OpRw = 2'b01,
    OpRs = 2'b10,
    OpRc = 2'b11
  } csr_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StDone
  } csr_unit_state_t;

  function automatic logic csr_is_readonly(csr_addr_t addr);
    return addr[CSR_ADDR_W-1 -: 2] == CSR_RO_BITS;
  endfunction

endpackage

// File: rtl/csr_alu.sv
// Read-modify-write value and write decision for one CSR instruction.
module csr_alu
  import csr_pkg::*;
#(
  parameter int unsigned XLEN = CSR_XLEN
) (
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_old,
  input  logic [XLEN-1:0] i_src,
  input  logic [4:0]      i_rs1_field,
  output logic [XLEN-1:0] o_new_val,
  output logic            o_do_write
);

  logic w_src_nonzero_field;
  assign w_src_nonzero_field = |i_rs1_field;

  always_comb begin
    o_new_val  = i_old;
    o_do_write = 1'b0;
    unique case (i_op)
      OpRw: begin
        o_new_val  = i_src;
        o_do_write = 1'b1;
      end
      // Set/clear with x0 or zimm=0 must not write, whatever the source value.
      OpRs: begin
        o_new_val  = i_old | i_src;
        o_do_write = w_src_nonzero_field;
      end
      OpRc: begin
        o_new_val  = i_old & ~i_src;
        o_do_write = w_src_nonzero_field;
      end
      default: begin
        o_new_val  = i_old;
        o_do_write = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/csr_unit.sv
// Zicsr execute-stage sequencer: read CSR, optionally write it back, return old value.
module csr_unit
  import csr_pkg::*;
#(
  parameter int unsigned XLEN   = CSR_XLEN,
  parameter int unsigned ADDR_W = CSR_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_csr_addr,
  input  logic [4:0]        in_rs1_field,
  input  logic [XLEN-1:0]   in_rs1_val,
  output logic [ADDR_W-1:0] csr_raddr,
  output logic              csr_ren,
  input  logic [XLEN-1:0]   csr_rdata,
  output logic [ADDR_W-1:0] csr_waddr,
  output logic              csr_wen,
  output logic [XLEN-1:0]   csr_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rd_data,
  output logic              out_illegal,
  output logic              flush_req
);

  csr_unit_state_t   r_state;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [4:0]        r_rs1_field;
  logic [XLEN-1:0]   r_rs1_val;
  logic              r_wrote;
  logic              r_csr_ren;
  logic              r_csr_wen;
  logic [ADDR_W-1:0] r_csr_raddr;
  logic [ADDR_W-1:0] r_csr_waddr;
  logic [XLEN-1:0]   r_csr_wdata;
  logic              r_out_valid;
  logic [XLEN-1:0]   r_out_rd_data;
  logic              r_out_illegal;
  logic              r_flush;

  logic [XLEN-1:0] w_src;
  logic [XLEN-1:0] w_new_val;
  logic            w_do_write;
  logic            w_readonly;

  // Immediate forms use the rs1 field itself as a zero-extended 5-bit value.
  assign w_src      = r_funct3[2] ? {{(XLEN-5){1'b0}}, r_rs1_field} : r_rs1_val;
  assign w_readonly = csr_is_readonly(csr_addr_t'(r_addr));

  csr_alu #(
    .XLEN (XLEN)
  ) u_csr_alu (
    .i_op        (r_funct3[1:0]),
    .i_old       (csr_rdata),
    .i_src       (w_src),
    .i_rs1_field (r_rs1_field),
    .o_new_val   (w_new_val),
    .o_do_write  (w_do_write)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= StIdle;
      r_funct3      <= '0;
      r_addr        <= '0;
      r_rs1_field   <= '0;
      r_rs1_val     <= '0;
      r_wrote       <= 1'b0;
      r_csr_ren     <= 1'b0;
      r_csr_wen     <= 1'b0;
      r_csr_raddr   <= '0;
      r_csr_waddr   <= '0;
      r_csr_wdata   <= '0;
      r_out_valid   <= 1'b0;
      r_out_rd_data <= '0;
      r_out_illegal <= 1'b0;
      r_flush       <= 1'b0;
    end else begin
      r_csr_ren <= 1'b0;
      r_csr_wen <= 1'b0;
      r_flush   <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_funct3    <= in_funct3;
            r_addr      <= in_csr_addr;
            r_rs1_field <= in_rs1_field;
            r_rs1_val   <= in_rs1_val;
            r_csr_raddr <= in_csr_addr;
            if (in_funct3[1:0] == 2'b00) begin
              r_out_illegal <= 1'b1;
              r_out_rd_data <= '0;
              r_out_valid   <= 1'b1;
              r_state       <= StDone;
            end else begin
              r_out_illegal <= 1'b0;
              r_csr_ren     <= 1'b1;
              r_state       <= StRead;
            end
          end
        end
        StRead: begin
          if (w_do_write && w_readonly) begin
            r_out_illegal <= 1'b1;
            r_out_rd_data <= '0;
            r_out_valid   <= 1'b1;
            r_state       <= StDone;
          end else if (w_do_write) begin
            r_out_rd_data <= csr_rdata;
            r_csr_wen     <= 1'b1;
            r_csr_waddr   <= r_addr;
            r_csr_wdata   <= w_new_val;
            r_state       <= StWrite;
          end else begin
            r_out_rd_data <= csr_rdata;
            r_out_valid   <= 1'b1;
            r_state       <= StDone;
          end
        end
        StWrite: begin
          r_wrote     <= 1'b1;
          r_out_valid <= 1'b1;
          r_state     <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            r_out_valid   <= 1'b0;
            r_out_illegal <= 1'b0;
            r_flush       <= r_wrote;
            r_wrote       <= 1'b0;
            r_state       <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign in_ready    = (r_state == StIdle);
  assign csr_ren     = r_csr_ren;
  assign csr_wen     = r_csr_wen;
  assign csr_raddr   = r_csr_raddr;
  assign csr_waddr   = r_csr_waddr;
  assign csr_wdata   = r_csr_wdata;
  assign out_valid   = r_out_valid;
  assign out_rd_data = r_out_rd_data;
  assign out_illegal = r_out_illegal;
  assign flush_req   = r_flush;

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: vector table, expectation queue, corner sequences.
module tb_csr_unit;
  import csr_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic [11:0] in_csr_addr;
  logic [4:0]  in_rs1_field;
  logic [63:0] in_rs1_val;
  logic [11:0] csr_raddr;
  logic        csr_ren;
  logic [63:0] csr_rdata;
  logic [11:0] csr_waddr;
  logic        csr_wen;
  logic [63:0] csr_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_rd_data;
  logic        out_illegal;
  logic        flush_req;

  csr_unit dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_funct3    (in_funct3),
    .in_csr_addr  (in_csr_addr),
    .in_rs1_field (in_rs1_field),
    .in_rs1_val   (in_rs1_val),
    .csr_raddr    (csr_raddr),
    .csr_ren      (csr_ren),
    .csr_rdata    (csr_rdata),
    .csr_waddr    (csr_waddr),
    .csr_wen      (csr_wen),
    .csr_wdata    (csr_wdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_rd_data  (out_rd_data),
    .out_illegal  (out_illegal),
    .flush_req    (flush_req)
  );

  always #5 clk = ~clk;

  // CSR file model: combinational read, write applied when csr_wen is seen.
  logic [63:0] mem [0:4095];
  assign csr_rdata = mem[csr_raddr];

  int n_wen = 0, n_ren = 0, n_flush = 0, n_overlap = 0;
  logic [63:0] last_wdata = '0;
  logic [11:0] last_waddr = '0;

  always @(negedge clk) begin
    if (csr_wen) begin
      n_wen++;
      last_wdata = csr_wdata;
      last_waddr = csr_waddr;
      mem[csr_waddr] = csr_wdata;
    end
    if (csr_ren) n_ren++;
    if (flush_req) n_flush++;
    if (csr_ren && csr_wen) n_overlap++;
  end

  typedef struct {
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [4:0]  fld;
    logic [63:0] val;
    logic [63:0] old;
    logic [63:0] rd;
    logic        ill;
    logic        wr;
    logic [63:0] wdata;
    int          lat;
  } vec_t;

  typedef struct {
    logic [63:0] rd;
    logic        ill;
    logic        wr;
    logic [63:0] wdata;
    logic [11:0] waddr;
    int          lat;
    int          ren;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic run_txn(input vec_t v, input int hold);
    int g, lat, w0, r0, f0;
    exp_t e;
    logic [63:0] rd_first;
    mem[v.addr] = v.old;
    g = 0;
    while (!in_ready && g < 20) begin
      step();
      g++;
    end
    chk("in_ready_before_issue", in_ready, 1);
    w0 = n_wen; r0 = n_ren; f0 = n_flush;
    in_valid     = 1'b1;
    in_funct3    = v.f3;
    in_csr_addr  = v.addr;
    in_rs1_field = v.fld;
    in_rs1_val   = v.val;
    e.rd = v.rd; e.ill = v.ill; e.wr = v.wr; e.wdata = v.wdata; e.waddr = v.addr;
    e.lat = v.lat; e.ren = (v.f3[1:0] != 2'b00) ? 1 : 0;
    exp_q.push_back(e);
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
    e = exp_q.pop_front();
    chk("latency", lat, e.lat);
    chk("out_valid", out_valid, 1);
    chk("out_rd_data", out_rd_data, e.rd);
    chk("out_illegal", out_illegal, e.ill);
    rd_first = out_rd_data;
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_out_valid", out_valid, 1);
      chk("hold_rd_stable", out_rd_data, rd_first);
      chk("hold_in_ready_low", in_ready, 0);
    end
    chk("wen_count", n_wen - w0, e.wr ? 1 : 0);
    chk("ren_count", n_ren - r0, e.ren);
    if (e.wr) begin
      chk("csr_wdata", last_wdata, e.wdata);
      chk("csr_waddr", last_waddr, e.waddr);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("out_valid_after_hs", out_valid, 0);
    step();
    chk("flush_count", n_flush - f0, e.wr ? 1 : 0);
    chk("in_ready_after_hs", in_ready, 1);
    chk("wen_count_after_hs", n_wen - w0, e.wr ? 1 : 0);
  endtask

  vec_t vecs[11];
  vec_t v;
  int w0;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    reset = 1'b1;
    in_valid = 1'b0; in_funct3 = '0; in_csr_addr = '0; in_rs1_field = '0; in_rs1_val = '0;
    out_ready = 1'b0;

    //          f3      addr    fld    val                old     rd      ill   wr    wdata  lat
    vecs[0]  = '{3'b001, 12'h340, 5'd5,  64'hDEAD_BEEF, 64'h5,    64'h5,    1'b0, 1'b1, 64'hDEAD_BEEF, 3};
    vecs[1]  = '{3'b010, 12'h300, 5'd0,  64'hFFFF,      64'h1800, 64'h1800, 1'b0, 1'b0, 64'h0,  2};
    vecs[2]  = '{3'b111, 12'h304, 5'd8,  64'h0,         64'h88,   64'h88,   1'b0, 1'b1, 64'h80, 3};
    vecs[3]  = '{3'b001, 12'hC00, 5'd1,  64'h7,         64'h1234, 64'h0,    1'b1, 1'b0, 64'h0,  2};
    vecs[4]  = '{3'b100, 12'h340, 5'd3,  64'h9,         64'h42,   64'h0,    1'b1, 1'b0, 64'h0,  1};
    vecs[5]  = '{3'b010, 12'h341, 5'd3,  64'hF0,        64'h0F,   64'h0F,   1'b0, 1'b1, 64'hFF, 3};
    vecs[6]  = '{3'b110, 12'h342, 5'd31, 64'h0,         64'h100,  64'h100,  1'b0, 1'b1, 64'h11F, 3};
    vecs[7]  = '{3'b011, 12'h343, 5'd2,  64'h0,         64'hAA,   64'hAA,   1'b0, 1'b1, 64'hAA, 3};
    vecs[8]  = '{3'b101, 12'h344, 5'd0,  64'h0,         64'h55,   64'h55,   1'b0, 1'b1, 64'h0,  3};
    vecs[9]  = '{3'b010, 12'hC01, 5'd0,  64'h3,         64'h77,   64'h77,   1'b0, 1'b0, 64'h0,  2};
    vecs[10] = '{3'b000, 12'h305, 5'd4,  64'h1,         64'h99,   64'h0,    1'b1, 1'b0, 64'h0,  1};

    repeat (3) step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_csr_ren", csr_ren, 0);
    chk("rst_csr_wen", csr_wen, 0);
    chk("rst_flush_req", flush_req, 0);
    chk("rst_out_illegal", out_illegal, 0);
    chk("rst_out_rd_data", out_rd_data, 0);
    chk("rst_csr_wdata", csr_wdata, 0);
    chk("rst_csr_waddr", csr_waddr, 0);
    chk("rst_csr_raddr", csr_raddr, 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 11; i++) run_txn(vecs[i], 0);

    // Consumer stalls for four cycles in DONE.
    v = vecs[0];
    v.old = 64'h1111;
    v.rd  = 64'h1111;
    v.val = 64'hCAFE;
    v.wdata = 64'hCAFE;
    run_txn(v, 4);

    // Reset while in READ for an instruction that would write.
    w0 = n_wen;
    mem[12'h340] = 64'h5;
    in_valid = 1'b1; in_funct3 = 3'b001; in_csr_addr = 12'h340;
    in_rs1_field = 5'd1; in_rs1_val = 64'h1234;
    step();
    in_valid = 1'b0;
    chk("abort_in_read", csr_ren, 1);
    reset = 1'b1;
    step();
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_csr_wen", csr_wen, 0);
    reset = 1'b0;
    repeat (3) step();
    chk("abort_no_write", n_wen - w0, 0);
    chk("abort_out_valid_later", out_valid, 0);

    chk("ren_wen_overlap", n_overlap, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
